// File: rtl/gpio_bank_pkg.sv
// Shared definitions for gpio_bank: register map and the per-pin pad drive rule.
package gpio_bank_pkg;

  localparam logic [2:0] REG_IN      = 3'd0;
  localparam logic [2:0] REG_OUT     = 3'd1;
  localparam logic [2:0] REG_DIR     = 3'd2;
  localparam logic [2:0] REG_OD      = 3'd3;
  localparam logic [2:0] REG_RISE_EN = 3'd4;
  localparam logic [2:0] REG_FALL_EN = 3'd5;
  localparam logic [2:0] REG_PEND    = 3'd6;
  localparam logic [2:0] REG_FILTER  = 3'd7;

  typedef struct packed {
    logic drive;
    logic enable;
  } pad_drive_t;

  // Open-drain pins only ever pull low: a 1 on OUT releases the pad instead of driving it.
  function automatic pad_drive_t padDrive(input logic outBit, input logic dirBit, input logic odBit);
    pad_drive_t p;
    if (odBit) begin
      p.drive  = 1'b0;
      p.enable = dirBit & ~outBit;
    end else begin
      p.drive  = outBit;
      p.enable = dirBit;
    end
    return p;
  endfunction

endpackage

// File: rtl/gpio_bank_if.sv
// Peripheral bus between the SoC and gpio_bank: single request, one-cycle ready pulse.
interface gpio_bank_if #(
  parameter int WIDTH = 8
);
  logic             valid;
  logic             write;
  logic [2:0]       addr;
  logic [WIDTH-1:0] wdata;
  logic             ready;
  logic [WIDTH-1:0] rdata;

  modport master (output valid, write, addr, wdata, input ready, rdata);
  modport slave  (input valid, write, addr, wdata, output ready, rdata);
endinterface

// File: rtl/gpio_bank_filter.sv
// gpio_filter: one pin's input path -- synchroniser, glitch filter, and edge pulses.
module gpio_filter #(
  parameter int SYNC_STAGES = 2,
  parameter int FILTER_BITS = 4
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  logic                   pin_i,
  input  logic [FILTER_BITS-1:0] thresh_i,
  output logic                   filt_o,
  output logic                   rise_o,
  output logic                   fall_o
);

  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic [FILTER_BITS-1:0] cnt_q, cnt_d;
  logic [FILTER_BITS:0]   cntNext;
  logic                   filt_q, filt_d;
  logic                   prev_q;
  logic                   synced;

  assign synced  = sync_q[SYNC_STAGES-1];
  assign sync_d  = {sync_q[SYNC_STAGES-2:0], pin_i};
  assign cntNext = {1'b0, cnt_q} + (FILTER_BITS+1)'(1);

  // Comparing with >= lets a lowered threshold take effect on a counter already past it.
  always_comb begin
    filt_d = filt_q;
    cnt_d  = '0;
    if (thresh_i == '0) begin
      filt_d = synced;
    end else if (synced != filt_q) begin
      if (cntNext >= {1'b0, thresh_i}) begin
        filt_d = ~filt_q;
      end else begin
        cnt_d = cntNext[FILTER_BITS-1:0];
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sync_q <= '0;
      cnt_q  <= '0;
      filt_q <= 1'b0;
      prev_q <= 1'b0;
    end else begin
      sync_q <= sync_d;
      cnt_q  <= cnt_d;
      filt_q <= filt_d;
      prev_q <= filt_q;
    end
  end

  assign filt_o = filt_q;
  assign rise_o = filt_q & ~prev_q;
  assign fall_o = ~filt_q & prev_q;

endmodule

// File: rtl/gpio_bank.sv
// gpio_bank: register-mapped GPIO with open-drain capable pad drive, filtered
// inputs and edge interrupts for WIDTH pins.
module gpio_bank
  import gpio_bank_pkg::*;
#(
  parameter int WIDTH       = 8,
  parameter int SYNC_STAGES = 2,
  parameter int FILTER_BITS = 4
) (
  input  logic             io_sys_clock,
  input  logic             io_sys_reset,
  gpio_bank_if.slave       bus,
  input  logic [WIDTH-1:0] pins_read,
  output logic [WIDTH-1:0] pins_write,
  output logic [WIDTH-1:0] pins_writeEnable,
  output logic             irq
);

  logic [WIDTH-1:0]       out_q, out_d, dir_q, dir_d, od_q, od_d;
  logic [WIDTH-1:0]       riseEn_q, riseEn_d, fallEn_q, fallEn_d;
  logic [WIDTH-1:0]       pend_q, pend_d, rdata_q, rdata_d;
  logic [FILTER_BITS-1:0] filter_q, filter_d;
  logic                   ready_q, ready_d;
  logic [WIDTH-1:0]       filtered, rise, fall, w1c;
  logic                   accept;

  for (genvar i = 0; i < WIDTH; i++) begin : g_pin
    pad_drive_t pd;

    gpio_filter #(
      .SYNC_STAGES(SYNC_STAGES),
      .FILTER_BITS(FILTER_BITS)
    ) u_filter (
      .clk_i   (io_sys_clock),
      .rst_ni  (io_sys_reset),
      .pin_i   (pins_read[i]),
      .thresh_i(filter_q),
      .filt_o  (filtered[i]),
      .rise_o  (rise[i]),
      .fall_o  (fall[i])
    );

    assign pd                  = padDrive(out_q[i], dir_q[i], od_q[i]);
    assign pins_write[i]       = pd.drive;
    assign pins_writeEnable[i] = pd.enable;
  end

  // A request is taken only while ready is low, so a held request completes every other cycle.
  assign accept = bus.valid & ~ready_q;

  always_comb begin
    out_d    = out_q;
    dir_d    = dir_q;
    od_d     = od_q;
    riseEn_d = riseEn_q;
    fallEn_d = fallEn_q;
    filter_d = filter_q;
    ready_d  = accept;
    rdata_d  = '0;
    w1c      = '0;
    if (accept && !bus.write) begin
      case (bus.addr)
        REG_IN:      rdata_d = filtered;
        REG_OUT:     rdata_d = out_q;
        REG_DIR:     rdata_d = dir_q;
        REG_OD:      rdata_d = od_q;
        REG_RISE_EN: rdata_d = riseEn_q;
        REG_FALL_EN: rdata_d = fallEn_q;
        REG_PEND:    rdata_d = pend_q;
        REG_FILTER:  rdata_d = WIDTH'(filter_q);
        default:     rdata_d = '0;
      endcase
    end
    if (accept && bus.write) begin
      case (bus.addr)
        REG_OUT:     out_d    = bus.wdata;
        REG_DIR:     dir_d    = bus.wdata;
        REG_OD:      od_d     = bus.wdata;
        REG_RISE_EN: riseEn_d = bus.wdata;
        REG_FALL_EN: fallEn_d = bus.wdata;
        REG_PEND:    w1c      = bus.wdata;
        REG_FILTER:  filter_d = bus.wdata[FILTER_BITS-1:0];
        default:     ;
      endcase
    end
    // New edges are OR-ed in after the clear so a coincident edge stays pending.
    pend_d = (pend_q & ~w1c) | (rise & riseEn_q) | (fall & fallEn_q);
  end

  always_ff @(posedge io_sys_clock or negedge io_sys_reset) begin
    if (!io_sys_reset) begin
      out_q    <= '0;
      dir_q    <= '0;
      od_q     <= '0;
      riseEn_q <= '0;
      fallEn_q <= '0;
      pend_q   <= '0;
      filter_q <= '0;
      ready_q  <= 1'b0;
      rdata_q  <= '0;
    end else begin
      out_q    <= out_d;
      dir_q    <= dir_d;
      od_q     <= od_d;
      riseEn_q <= riseEn_d;
      fallEn_q <= fallEn_d;
      pend_q   <= pend_d;
      filter_q <= filter_d;
      ready_q  <= ready_d;
      rdata_q  <= rdata_d;
    end
  end

  assign bus.ready = ready_q;
  assign bus.rdata = rdata_q;
  assign irq       = |pend_q;

endmodule
